// File: rtl/tiled_pixel_framebuffer.sv
`default_nettype none
// ============================================================================
// Module   : tiled_pixel_framebuffer
// Brief    : Lane-packed, optionally double-buffered pixel framebuffer with
//            render write port, scanout read port and hardware clear engine.
// Revision : 1.0
// ============================================================================
module tiled_pixel_framebuffer #(
    parameter int H_BITS     = 8,
    parameter int WIDTH      = 256,
    parameter int HEIGHT     = 240,
    parameter int V_BITS     = 8,
    parameter int PIX_BITS   = 6,
    parameter int COL_WIDTH  = 8,
    parameter int LANES      = 8,
    parameter int DOUBLE_BUF = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [H_BITS-1:0]   wr_x,
    input  logic [V_BITS-1:0]   wr_y,
    input  logic [PIX_BITS-1:0] wr_color,
    output logic                wr_drop,
    input  logic                frame_done,
    input  logic                clear_start,
    input  logic [PIX_BITS-1:0] clear_color,
    output logic                clear_busy,
    input  logic                rd_en,
    input  logic [H_BITS-1:0]   rd_x,
    input  logic [V_BITS-1:0]   rd_y,
    output logic                rd_valid,
    output logic [PIX_BITS-1:0] rd_color,
    input  logic                vblank_start,
    output logic                front_bank
);

    localparam int c_LB        = $clog2(LANES);
    localparam int c_IDX_W     = H_BITS + V_BITS;
    localparam int c_DEPTH     = HEIGHT * (2 ** H_BITS) / LANES;
    localparam int c_AW        = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int c_PAW       = (DOUBLE_BUF != 0) ? c_AW + 1 : c_AW;
    localparam int c_WORD_W    = LANES * COL_WIDTH;
    localparam logic [c_AW-1:0]   c_LAST = c_AW'(c_DEPTH - 1);
    localparam logic [H_BITS:0]   c_XLIM = (H_BITS + 1)'(WIDTH);
    localparam logic [V_BITS:0]   c_YLIM = (V_BITS + 1)'(HEIGHT);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_AW-1:0]      r_clr_cnt;
    logic [PIX_BITS-1:0]  r_clr_color;
    logic                 r_front_bank;
    logic                 r_swap_pending;
    logic                 w_wr_bank;
    logic                 w_rd_bank;

    logic                 w_wr_fire;
    logic                 w_wr_in_range;
    logic [c_IDX_W-1:0]   w_wr_idx;
    logic [c_AW-1:0]      w_wr_word;
    logic [c_LB-1:0]      w_wr_lane;
    logic [COL_WIDTH-1:0] w_wr_col;
    logic [COL_WIDTH-1:0] w_clr_col;

    logic                 w_rd_in_range;
    logic [c_IDX_W-1:0]   w_rd_idx;
    logic [c_AW-1:0]      w_rd_word;
    logic [c_LB-1:0]      w_rd_lane;
    logic [c_PAW-1:0]     w_rd_addr;

    logic [LANES-1:0]     r_we;
    logic [c_PAW-1:0]     r_waddr;
    logic [c_WORD_W-1:0]  r_wdata;
    logic [c_WORD_W-1:0]  r_mem [2 ** c_PAW];
    logic [c_WORD_W-1:0]  r_ram_q;

    logic                 r_rd_v1;
    logic                 r_rd_inr1;
    logic [c_LB-1:0]      r_rd_lane1;
    logic [PIX_BITS-1:0]  w_rd_sel;
    logic                 w_unused;

    // ------------------------------------------------------------------------
    // Bank selection
    // ------------------------------------------------------------------------
    if (DOUBLE_BUF != 0) begin : g_dbuf
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_front_bank   <= 1'b0;
                r_swap_pending <= 1'b0;
            end else if (vblank_start && (r_swap_pending || frame_done)) begin
                r_front_bank   <= ~r_front_bank;
                r_swap_pending <= 1'b0;
            end else if (frame_done) begin
                r_swap_pending <= 1'b1;
            end
        end
        assign w_wr_bank = ~r_front_bank;
        assign w_rd_bank = r_front_bank;
    end else begin : g_single
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_front_bank   <= 1'b0;
                r_swap_pending <= 1'b0;
            end else begin
                r_front_bank   <= 1'b0;
                r_swap_pending <= 1'b0;
            end
        end
        assign w_wr_bank = 1'b0;
        assign w_rd_bank = 1'b0;
    end

    assign front_bank = r_front_bank;

    // ------------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clear_start)         w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_clr_cnt == c_LAST) w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
        end else if (r_state == S_IDLE && clear_start) begin
            r_clr_cnt   <= '0;
            r_clr_color <= clear_color;
        end else if (r_state == S_CLEAR) begin
            r_clr_cnt   <= r_clr_cnt + 1'b1;
        end
    end

    assign clear_busy = (r_state == S_CLEAR);
    assign wr_ready   = (r_state == S_IDLE);

    // ------------------------------------------------------------------------
    // Write path: one registered stage between handshake and RAM
    // ------------------------------------------------------------------------
    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_wr_idx      = {wr_y, wr_x};
    assign w_wr_word     = c_AW'(w_wr_idx >> c_LB);
    assign w_wr_lane     = w_wr_idx[c_LB-1:0];
    assign w_wr_in_range = ({1'b0, wr_x} < c_XLIM) && ({1'b0, wr_y} < c_YLIM);
    assign w_wr_col      = COL_WIDTH'(wr_color);
    assign w_clr_col     = COL_WIDTH'(r_clr_color);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            wr_drop <= 1'b0;
        end else begin
            r_we    <= '0;
            wr_drop <= 1'b0;
            if (r_state == S_CLEAR) begin
                r_we    <= '1;
                r_waddr <= c_PAW'({w_wr_bank, r_clr_cnt});
                r_wdata <= {LANES{w_clr_col}};
            end else if (w_wr_fire) begin
                if (w_wr_in_range) begin
                    r_we    <= {{(LANES-1){1'b0}}, 1'b1} << w_wr_lane;
                    r_waddr <= c_PAW'({w_wr_bank, w_wr_word});
                    r_wdata <= {LANES{w_wr_col}};
                end else begin
                    wr_drop <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read-first RAM with per-lane write enables
    // ------------------------------------------------------------------------
    assign w_rd_idx      = {rd_y, rd_x};
    assign w_rd_word     = c_AW'(w_rd_idx >> c_LB);
    assign w_rd_lane     = w_rd_idx[c_LB-1:0];
    assign w_rd_in_range = ({1'b0, rd_x} < c_XLIM) && ({1'b0, rd_y} < c_YLIM);
    assign w_rd_addr     = c_PAW'({w_rd_bank, (w_rd_in_range ? w_rd_word : {c_AW{1'b0}})});

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (r_we[i]) begin
                r_mem[r_waddr][i*COL_WIDTH +: COL_WIDTH] <= r_wdata[i*COL_WIDTH +: COL_WIDTH];
            end
        end
        if (rd_en) begin
            r_ram_q <= r_mem[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline: RAM data at +1, lane-selected pixel at +2
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_rd_lane1 == c_LB'(i)) begin
                w_rd_sel = r_ram_q[i*COL_WIDTH +: PIX_BITS];
            end
        end
    end

    // Upper lane bits never carry pixel data.
    assign w_unused = ^r_ram_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_v1    <= 1'b0;
            r_rd_inr1  <= 1'b0;
            r_rd_lane1 <= '0;
            rd_valid   <= 1'b0;
            rd_color   <= '0;
        end else begin
            r_rd_v1    <= rd_en;
            r_rd_inr1  <= w_rd_in_range;
            r_rd_lane1 <= w_rd_lane;
            rd_valid   <= r_rd_v1;
            if (r_rd_v1) begin
                rd_color <= r_rd_inr1 ? w_rd_sel : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tiled_pixel_framebuffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tiled_pixel_framebuffer
// Brief    : Directed scoreboard bench for tiled_pixel_framebuffer.
// Revision : 1.0
// ============================================================================
module tb_tiled_pixel_framebuffer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       wr_valid = 0, wr_ready, wr_drop, frame_done = 0, clear_start = 0, clear_busy;
    logic [7:0] wr_x = 0, wr_y = 0, rd_x = 0, rd_y = 0;
    logic [5:0] wr_color = 0, clear_color = 0, rd_color;
    logic       rd_en = 0, rd_valid, vblank_start = 0, front_bank;

    // Single-bank instance with a 512-pixel pitch and 256 visible pixels
    logic       s_wr_valid = 0, s_wr_ready, s_wr_drop, s_frame_done = 0, s_clear_busy;
    logic [8:0] s_wr_x = 0, s_rd_x = 0;
    logic [2:0] s_wr_y = 0, s_rd_y = 0;
    logic [5:0] s_wr_color = 0, s_rd_color;
    logic       s_rd_en = 0, s_rd_valid, s_vblank_start = 0, s_front_bank;

    tiled_pixel_framebuffer u_dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .wr_drop(wr_drop), .frame_done(frame_done),
        .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_color(rd_color),
        .vblank_start(vblank_start), .front_bank(front_bank)
    );

    tiled_pixel_framebuffer #(
        .H_BITS(9), .WIDTH(256), .HEIGHT(4), .V_BITS(3), .DOUBLE_BUF(0)
    ) u_sm (
        .clk(clk), .reset(reset),
        .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_x(s_wr_x), .wr_y(s_wr_y),
        .wr_color(s_wr_color), .wr_drop(s_wr_drop), .frame_done(s_frame_done),
        .clear_start(1'b0), .clear_color(6'd0), .clear_busy(s_clear_busy),
        .rd_en(s_rd_en), .rd_x(s_rd_x), .rd_y(s_rd_y), .rd_valid(s_rd_valid),
        .rd_color(s_rd_color), .vblank_start(s_vblank_start), .front_bank(s_front_bank)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0] color;
        int         due;
    } rd_exp_t;

    rd_exp_t    sb[$];
    rd_exp_t    mon_e;
    logic [5:0] mdl [2][61440];
    logic       fbm = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int x, input int y, input logic [5:0] c, input bit chk);
        wr_valid = 1'b1;
        wr_x = 8'(x);
        wr_y = 8'(y);
        wr_color = c;
        tick();
        wr_valid = 1'b0;
        if (x < 256 && y < 240) mdl[!fbm][y*256 + x] = c;
        if (chk) check("wr_drop", wr_drop, (y >= 240) ? 1 : 0);
    endtask

    task automatic rd_issue(input int x, input int y);
        rd_exp_t e;
        rd_en = 1'b1;
        rd_x = 8'(x);
        rd_y = 8'(y);
        e.color = (x < 256 && y < 240) ? mdl[fbm][y*256 + x] : 6'd0;
        e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic s_wr(input int x, input int y, input logic [5:0] c, input logic exp_drop);
        s_wr_valid = 1'b1;
        s_wr_x = 9'(x);
        s_wr_y = 3'(y);
        s_wr_color = c;
        tick();
        s_wr_valid = 1'b0;
        check("s_wr_drop", s_wr_drop, exp_drop);
    endtask

    task automatic s_read(input int x, input int y, input logic [5:0] exp);
        s_rd_en = 1'b1;
        s_rd_x = 9'(x);
        s_rd_y = 3'(y);
        tick();
        s_rd_en = 1'b0;
        tick();
        check("s_rd_valid", s_rd_valid, 1);
        check("s_rd_color", s_rd_color, exp);
    endtask

    // Scoreboard: every rd_valid pops one expectation, including its due cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rd_color", rd_color, mon_e.color);
                    check("rd_latency", cyc, mon_e.due);
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                check("rd_missing", 0, 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rdy_bad;
        logic [5:0] c;

        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_wr_drop", wr_drop, 0);
        check("rst_clear_busy", clear_busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_color", rd_color, 0);
        check("rst_front_bank", front_bank, 0);
        reset = 1'b0;
        tick();

        // Full clear of back bank 1; a second clear_start mid-way is ignored
        clear_color = 6'h15;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        n = 0;
        rdy_bad = 0;
        while (clear_busy && n < 10000) begin
            n++;
            if (wr_ready) rdy_bad++;
            clear_start = (n == 50);
            clear_color = (n == 50) ? 6'h3F : 6'h15;
            tick();
        end
        clear_start = 1'b0;
        check("clear_busy_cycles", n, 7680);
        check("wr_ready_in_clear", rdy_bad, 0);
        for (int i = 0; i < 61440; i++) mdl[1][i] = 6'h15;

        wr(10, 3, 6'h2A, 1'b1);
        wr(0, 240, 6'h3F, 1'b1);
        wr(17, 255, 6'h01, 1'b1);
        for (int x = 0; x < 256; x++) wr(x, 5, 6'((x * 7) + 3), 1'b0);

        // Swap after a long pending interval
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        repeat (398) tick();
        vblank_start = 1'b1;
        check("front_before_vblank", front_bank, 0);
        tick();
        vblank_start = 1'b0;
        fbm = 1'b1;
        check("front_after_vblank", front_bank, 1);

        rd_issue(10, 3);   tick();
        rd_issue(9, 3);    tick();
        rd_issue(11, 3);   tick();
        rd_issue(0, 0);    tick();
        rd_issue(255, 239); tick();
        rd_issue(0, 240);  tick();
        rd_en = 1'b0;
        repeat (4) tick();

        // Back-to-back scanout of row 5 while the render side rewrites the back bank
        for (int x = 0; x < 256; x++) begin
            rd_issue(x, 5);
            c = 6'((x * 13) ^ 6'h2C);
            wr_valid = 1'b1;
            wr_x = 8'(x);
            wr_y = 8'd5;
            wr_color = c;
            mdl[0][5*256 + x] = c;
            tick();
        end
        rd_en = 1'b0;
        wr_valid = 1'b0;
        repeat (4) tick();

        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        check("no_pending_no_swap", front_bank, 1);

        frame_done = 1'b1;
        vblank_start = 1'b1;
        tick();
        frame_done = 1'b0;
        vblank_start = 1'b0;
        fbm = 1'b0;
        check("same_cycle_swap", front_bank, 0);
        rd_issue(7, 5); tick();
        rd_issue(200, 5); tick();
        rd_en = 1'b0;
        repeat (4) tick();

        // Repeated frame_done yields a single swap
        frame_done = 1'b1;
        tick();
        tick();
        frame_done = 1'b0;
        tick();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        fbm = 1'b1;
        check("double_done_swap", front_bank, 1);
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        check("second_vblank_no_swap", front_bank, 1);

        // Reset mid-clear with reads in flight
        clear_color = 6'h09;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (100) tick();
        check("busy_before_reset", clear_busy, 1);
        rd_issue(1, 5); tick();
        rd_issue(2, 5); tick();
        rd_issue(3, 5); tick();
        check("rd_valid_before_reset", rd_valid, 1);
        rd_en = 1'b0;
        reset = 1'b1;
        sb.delete();
        #1;
        check("reset_clear_busy", clear_busy, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_color", rd_color, 0);
        check("reset_front_bank", front_bank, 0);
        repeat (2) tick();
        reset = 1'b0;
        fbm = 1'b0;
        tick();
        check("post_reset_wr_ready", wr_ready, 1);
        check("post_reset_clear_busy", clear_busy, 0);

        // Single-bank instance: x range, read-first collision, inert swap
        s_wr(300, 1, 6'h11, 1'b1);
        s_wr(5, 1, 6'h11, 1'b0);
        s_wr(6, 1, 6'h01, 1'b0);
        s_wr(0, 4, 6'h3F, 1'b1);
        tick();
        s_wr_valid = 1'b1;
        s_wr_x = 9'd6;
        s_wr_y = 3'd1;
        s_wr_color = 6'h22;
        tick();
        s_wr_valid = 1'b0;
        s_rd_en = 1'b1;
        s_rd_x = 9'd6;
        s_rd_y = 3'd1;
        tick();
        s_rd_en = 1'b0;
        tick();
        check("s_read_first_valid", s_rd_valid, 1);
        check("s_read_first_color", s_rd_color, 6'h01);
        s_read(6, 1, 6'h22);
        s_read(5, 1, 6'h11);
        s_read(300, 1, 6'h00);
        s_frame_done = 1'b1;
        s_vblank_start = 1'b1;
        tick();
        s_frame_done = 1'b0;
        s_vblank_start = 1'b0;
        check("s_front_bank_fixed", s_front_bank, 0);

        repeat (5) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
